store_buffer: RTL and testbench

- Write buffer between the write-through data cache and main data memory.
- Accepts stores from the cache's write-through path in one cycle and queues them in a FIFO.
- Drains the queue to memory through a req/ack handshake, so a slow memory does not stall the store stream.
- Reports load-address conflicts with pending stores so the hazard unit stalls the load until the store is in memory.

---
 rtl/store_buffer.sv | 194 +++++++++++++++++++
 tb/tb_store_buffer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer
//   Write buffer between the write-through data cache and data memory.
//   Stores are accepted in one cycle into a DEPTH-entry FIFO and drained to
//   memory one entry at a time through a mem_req/mem_ack handshake. Loads are
//   compared (word granularity) against every pending entry to report
//   read-after-write hazards.
//
// Parameters
//   ADDR_WIDTH  address width
//   DATA_WIDTH  data width
//   DEPTH       FIFO entries (power of two, >= 2)
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   st_valid/st_ready          store handshake from the cache write path
//   st_addr/st_data/st_mode    store byte address, data, address mode
//   ld_valid/ld_addr           load in memory stage
//   ld_conflict                load word overlaps a pending store
//   mem_req/mem_ack            head write handshake towards data memory
//   mem_addr/mem_wd/mem_mode   head entry (zero while no write is requested)
//   count/empty                occupancy
//
// Build option
//   STORE_FWD_EN  when defined, adds ld_fwd_valid/ld_fwd_data: a load whose
//                 newest matching entry is a word store gets that data
//                 forwarded instead of a conflict.
module store_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [ADDR_WIDTH-1:0]   st_addr,
  input  logic [DATA_WIDTH-1:0]   st_data,
  input  logic [2:0]              st_mode,
  input  logic                    ld_valid,
  input  logic [ADDR_WIDTH-1:0]   ld_addr,
  output logic                    ld_conflict,
  output logic                    mem_req,
  input  logic                    mem_ack,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wd,
  output logic [2:0]              mem_mode,
  output logic [$clog2(DEPTH):0]  count,
`ifdef STORE_FWD_EN
  output logic                    ld_fwd_valid,
  output logic [DATA_WIDTH-1:0]   ld_fwd_data,
`endif
  output logic                    empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Word-store encoding of the address mode field (sb=000, sh=001, sw=010).
  localparam logic [2:0] MODE_WORD = 3'b010;

  typedef enum logic {
    S_IDLE,
    S_WRITE
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        head_q, head_d;
  logic [PTR_W-1:0]        tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]   addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0]   addr_d [DEPTH];
  logic [DATA_WIDTH-1:0]   data_q [DEPTH];
  logic [DATA_WIDTH-1:0]   data_d [DEPTH];
  logic [2:0]              mode_q [DEPTH];
  logic [2:0]              mode_d [DEPTH];

  logic                    enq;
  logic                    deq;
  logic [DEPTH-1:0]        match;

  // Byte offset is irrelevant for word-granular hazard detection.
  logic [1:0]              unused_ld_offset;
  assign unused_ld_offset = ld_addr[1:0];

  assign st_ready = (count_q < CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign mem_req  = (state_q == S_WRITE);
  assign mem_addr = mem_req ? addr_q[head_q] : '0;
  assign mem_wd   = mem_req ? data_q[head_q] : '0;
  assign mem_mode = mem_req ? mode_q[head_q] : '0;

  // FIFO storage and pointers. With 0 < count < DEPTH the head and tail slots
  // differ, so a simultaneous enqueue and dequeue never touch the same entry.
  always_comb begin
    enq     = st_valid && st_ready;
    deq     = (state_q == S_WRITE) && mem_ack;
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mode_d  = mode_q;
    if (enq) begin
      addr_d[tail_q]  = st_addr;
      data_d[tail_q]  = st_data;
      mode_d[tail_q]  = st_mode;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    if (deq) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
  end

  // Drain FSM
  //   state   | meaning
  //   S_IDLE  | nothing requested; leave when the registered count is nonzero
  //   S_WRITE | mem_req high, head entry on mem_*; leave when the last entry
  //           | is acknowledged and no store arrives in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_WRITE;
      S_WRITE: if (deq && (count_d == '0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid_q[i] &&
                 (addr_q[i][ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2]);
    end
  end

`ifdef STORE_FWD_EN
  logic                  hit;
  logic                  hit_word;
  logic [DATA_WIDTH-1:0] hit_data;
  logic [PTR_W-1:0]      idx;

  // Valid entries are contiguous from head, so walking oldest to newest and
  // letting later matches overwrite earlier ones selects the newest store.
  always_comb begin
    hit      = 1'b0;
    hit_word = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if (match[idx]) begin
        hit      = 1'b1;
        hit_word = (mode_q[idx] == MODE_WORD);
        hit_data = data_q[idx];
      end
    end
  end

  assign ld_fwd_valid = ld_valid && hit && hit_word;
  assign ld_fwd_data  = ld_fwd_valid ? hit_data : '0;
  assign ld_conflict  = ld_valid && hit && !hit_word;
`else
  assign ld_conflict  = ld_valid && (|match);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        mode_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic [2:0]    st_mode;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          ld_conflict;
  logic          mem_req;
  logic          mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [2:0]    mem_mode;
  logic [2:0]    count;
  logic          empty;
`ifdef STORE_FWD_EN
  logic          ld_fwd_valid;
  logic [DW-1:0] ld_fwd_data;
`endif

  store_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_mode(st_mode),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_mode(mem_mode),
    .count(count),
`ifdef STORE_FWD_EN
    .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
`endif
    .empty(empty)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [2:0]    m;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a store and hold it until accepted; returns one step after the
  // accepting edge, i.e. in the cycle where the entry is first visible.
  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] m);
    wr_t w;
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_mode  = m;
    for (int i = 0; i < 50 && !st_ready; i++) tick();
    if (!st_ready) begin
      timeout("store_accept");
    end else begin
      w.a = a; w.d = d; w.m = m;
      exp_q.push_back(w);
      tick();
    end
    st_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 100 && !empty; i++) tick();
    if (!empty) timeout("drain");
  endtask

  // Monitor: every accepted memory write must match the oldest expected store.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req && mem_ack) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL mem_write_unexpected: got addr 0x%0h with nothing expected", mem_addr);
        end else begin
          w = exp_q.pop_front();
          chk("mem_addr", 64'(mem_addr), 64'(w.a));
          chk("mem_wd",   64'(mem_wd),   64'(w.d));
          chk("mem_mode", 64'(mem_mode), 64'(w.m));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_mode = '0;
    ld_valid = 1'b0; ld_addr = '0; mem_ack = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_st_ready", 64'(st_ready), 1);
    chk("rst_mem_req",  64'(mem_req),  0);
    chk("rst_empty",    64'(empty),    1);
    chk("rst_count",    64'(count),    0);
    chk("rst_conflict", 64'(ld_conflict), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    chk("rst_mem_wd",   64'(mem_wd),   0);
    chk("rst_mem_mode", 64'(mem_mode), 0);

    // Single store, mem_ack tied high; ack while idle must be ignored
    mem_ack = 1'b1;
    store(32'h100, 32'hDEAD_BEEF, 3'b010);
    chk("t1_count_n1",   64'(count),   1);
    chk("t1_req_n1",     64'(mem_req), 0);
    tick();
    chk("t1_req_n2",     64'(mem_req), 1);
    chk("t1_addr_n2",    64'(mem_addr), 32'h100);
    chk("t1_wd_n2",      64'(mem_wd),   32'hDEAD_BEEF);
    tick();
    chk("t1_empty_n3",   64'(empty),   1);
    chk("t1_req_n3",     64'(mem_req), 0);

    // Fill with memory stalled, fifth store held until a slot frees
    mem_ack = 1'b0;
    store(32'h0, 32'h1111_0000, 3'b010);
    store(32'h4, 32'h1111_0004, 3'b010);
    store(32'h8, 32'h0000_00AA, 3'b000);
    store(32'hC, 32'h1111_000C, 3'b010);
    chk("t2_full_ready", 64'(st_ready), 0);
    chk("t2_full_count", 64'(count),    4);
    st_valid = 1'b1; st_addr = 32'h10; st_data = 32'h1111_0010; st_mode = 3'b010;
    tick(); tick();
    chk("t2_held_count", 64'(count),    4);
    chk("t2_held_ready", 64'(st_ready), 0);
    mem_ack = 1'b1;
    store(32'h10, 32'h1111_0010, 3'b010);
    wait_empty();
    mem_ack = 1'b0;
    chk("t2_drained_count", 64'(count), 0);

    // Word-granular load conflict, including the head entry under write
    store(32'h20, 32'hCAFE_F00D, 3'b010);
    ld_valid = 1'b1; ld_addr = 32'h22; #1;
    chk("t3_conf_same_word", 64'(ld_conflict), FWD ? 0 : 1);
    ld_addr = 32'h24; #1;
    chk("t3_conf_next_word", 64'(ld_conflict), 0);
    ld_valid = 1'b0; ld_addr = 32'h22; #1;
    chk("t3_conf_no_load",   64'(ld_conflict), 0);
    tick();
    chk("t3_req", 64'(mem_req), 1);
    ld_valid = 1'b1; #1;
    chk("t3_conf_head_writing", 64'(ld_conflict), FWD ? 0 : 1);
    mem_ack = 1'b1;
    tick();
    chk("t3_conf_after_ack", 64'(ld_conflict), 0);
    mem_ack = 1'b0; ld_valid = 1'b0;

    // Full buffer, continuous stores, memory acking every cycle: after the
    // first dequeue st_ready rises and occupancy holds at DEPTH-1 with one
    // store in and one write out per cycle.
    store(32'h30, 32'h3000_0000, 3'b010);
    store(32'h34, 32'h3000_0001, 3'b010);
    store(32'h38, 32'h3000_0002, 3'b010);
    store(32'h3C, 32'h3000_0003, 3'b010);
    chk("t4_full_count", 64'(count), 4);
    mem_ack = 1'b1;
    st_valid = 1'b1; st_mode = 3'b010; st_addr = 32'h50; st_data = 32'h5000_0000;
    for (int c = 0; c < 8; c++) begin
      bit acc;
      wr_t w;
      acc = st_ready;
      if (acc) begin
        w.a = st_addr; w.d = st_data; w.m = st_mode;
        exp_q.push_back(w);
      end
      tick();
      if (acc) begin
        st_addr = st_addr + 32'h4;
        st_data = st_data + 32'h1;
      end
      chk("t4_steady_count", 64'(count), 3);
      chk("t4_steady_req",   64'(mem_req), 1);
    end
    st_valid = 1'b0;
    wait_empty();
    mem_ack = 1'b0;

    // Reset in the middle of a write discards everything
    store(32'h60, 32'h6000_0000, 3'b010);
    store(32'h64, 32'h6000_0001, 3'b010);
    store(32'h68, 32'h6000_0002, 3'b010);
    chk("t5_pre_req",   64'(mem_req), 1);
    chk("t5_pre_count", 64'(count),   3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    chk("t5_req",      64'(mem_req),  0);
    chk("t5_count",    64'(count),    0);
    chk("t5_st_ready", 64'(st_ready), 1);
    chk("t5_empty",    64'(empty),    1);
    mem_ack = 1'b1;
    tick(); tick();
    chk("t5_no_req_after", 64'(mem_req), 0);
    mem_ack = 1'b0;

`ifdef STORE_FWD_EN
    store(32'h40, 32'h1234_5678, 3'b010);
    store(32'h44, 32'h0000_00AA, 3'b000);
    ld_valid = 1'b1; ld_addr = 32'h40; #1;
    chk("fwd_word_valid",    64'(ld_fwd_valid), 1);
    chk("fwd_word_data",     64'(ld_fwd_data),  32'h1234_5678);
    chk("fwd_word_conflict", 64'(ld_conflict),  0);
    ld_addr = 32'h44; #1;
    chk("fwd_byte_conflict", 64'(ld_conflict),  1);
    chk("fwd_byte_valid",    64'(ld_fwd_valid), 0);
    ld_valid = 1'b0;
    mem_ack = 1'b1;
    wait_empty();
    mem_ack = 1'b0;
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("all_writes_seen", 64'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
